sub_mem_loader: RTL and testbench
=================================

# sub_mem_loader

Main-core-side write engine that fills a subcore data memory through its two main-core write ports (`u_n_in_from_main`, `l_n_in_from_main`). It accepts one load command (base word address, word count) and then a 32-bit word stream from the main core. Consecutive words are paired and written two per cycle, upper lane at the even offset and lower lane at the odd offset. It sits between the main-core transfer logic and each subcore's `memory` block; memory gives these ports priority, so the loader never stalls on the memory side.

## Interface
- `ADDR_W`, 17, word-address width (memory depth 2**17 words)
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  load command present
- `cmd_ready`  out  1  loader idle and able to take a command
- `cmd_base`  in  ADDR_W  first word address
- `cmd_len`  in  ADDR_W+1  word count, 0..2**ADDR_W
- `abort`  in  1  synchronous cancel of the current command
- `wdata_valid`  in  1  stream word present
- `wdata_ready`  out  1  loader accepts a stream word
- `wdata`  in  32  stream word
- `u_n_out`  out  data_in  upper-lane write to memory
- `l_n_out`  out  data_in  lower-lane write to memory
- `busy`  out  1  command in progress (LOAD or DONE)
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. `cmd_valid`&&`cmd_ready` latches base and len, clears the accepted count k, and goes to LOAD.
  - LOAD: `wdata_ready`=1 while k<len. Each handshake increments k.
    - A word with even k is held in the hold register.
    - A word with odd k is issued on the next cycle as a pair: u.addr=base+k-1 with u.din=hold; l.addr=base+k with l.din=wdata; both we=1.
    - When k reaches len, go to DONE.
  - DONE: lasts one cycle, `done`=1, then IDLE.
- Odd len: the last held word is written alone in the DONE cycle (u.we=1, l.we=0).
- Even len: the final pair is written in the DONE cycle.
- len=0: no writes; DONE on the cycle after acceptance.
- Addresses are ADDR_W bits wide and wrap modulo 2**ADDR_W, e.g. base=0x1FFFF pairs with 0x00000. Output addr is zero-extended to 32 bits.
- `dout` fields are driven to 0. `we` is 1 for exactly one cycle per write.
- `abort` in LOAD or DONE:
  - next state IDLE, hold register discarded, no pending write issued, `done` not pulsed.
  - A pair accepted in the same cycle as abort is dropped.
  - `abort` in IDLE is ignored.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- Simultaneous `wdata_valid` and k==len: the word is not accepted.

## Timing
- Reset values: state=IDLE; `cmd_ready`=1 (combinational from state); `wdata_ready`=0; `busy`=0; `done`=0; u/l addr=0, din=0, we=0, dout=0. All registers reset asynchronously.
- Reset mid-operation: all `we` drop to 0 immediately; the command is lost.
- Write ports are registered. A pair appears 1 cycle after the odd-word handshake.
- Throughput: 1 word per cycle with continuous valid, i.e. one pair write every 2 cycles.
- Command acceptance at cycle T: `wdata_ready`=1 from T+1.
- Last word accepted at cycle L: DONE, the final write and `done` all occur at L+1; `cmd_ready`=1 at L+2.
- Back-to-back commands: minimum 1 IDLE cycle between commands.

## Structure
- `data_in` (addr[31:0], din[31:0], we, dout[31:0]) and `DATA_MEM_DEPTH` live in `inst_package`. `ADDR_W` must equal $clog2(DATA_MEM_DEPTH).
- FSM state enum (IDLE/LOAD/DONE) is local to the module.
- Single module. The write-lane formatting (pair/single to two `data_in` registers) may be split out as `sub_mem_pair_writer`; this is optional.

## Test plan
- base=0x00100, len=4, words A,B,C,D continuous → pair (0x100=A, 0x101=B) at T+3, pair (0x102=C, 0x103=D) with `done` at T+5; `cmd_ready` back at T+6.
- base=0x00010, len=3, words with gaps on `wdata_valid` → pair (0x10, 0x11), then u-only write 0x12 with l.we=0 in the DONE cycle.
- base=0x1FFFF, len=2 → u.addr=0x1FFFF, l.addr=0x00000, same cycle.
- len=0 → no we ever asserted, `done` at T+1, `wdata_ready` never 1.
- `abort` after 3 of 8 words → no further we, `done` stays 0, `cmd_ready`=1 next cycle. A new len=2 command then writes correctly.
- rstn low mid-LOAD with held word → outputs zero asynchronously; after release, state IDLE, `cmd_ready`=1, no stale write.

Source files
------------

// File: rtl/sub_mem_loader_pkg.sv
// rtl/sub_mem_loader_pkg.sv - shared memory-port types and sizing for the subcore memory loader
package sub_mem_loader_pkg;

  localparam int DATA_MEM_DEPTH = 1 << 17;
  localparam int MEM_ADDR_W     = $clog2(DATA_MEM_DEPTH);

  // One main-core write port into a subcore data memory.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
  } data_in;

  localparam data_in DATA_IN_IDLE = '0;

endpackage

// File: rtl/sub_mem_loader_if.sv
// rtl/sub_mem_loader_if.sv - command, word stream and memory write-port bundle of the loader
interface sub_mem_loader_if #(
  parameter int ADDR_W = 17
);
  import sub_mem_loader_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic              abort;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [31:0]       wdata;
  data_in            u_n_out;
  data_in            l_n_out;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_base, cmd_len, abort, wdata_valid, wdata,
    input  cmd_ready, wdata_ready, u_n_out, l_n_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, abort, wdata_valid, wdata,
    output cmd_ready, wdata_ready, u_n_out, l_n_out, busy, done
  );

endinterface

// File: rtl/sub_mem_loader_pair_writer.sv
// rtl/sub_mem_loader_pair_writer.sv - registers a pair or single write onto the two memory lanes
module sub_mem_pair_writer
  import sub_mem_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pair_we,    // odd word accepted: write held word and this word
  input  logic              single_we,  // even last word accepted: write it alone on upper lane
  input  logic [ADDR_W-1:0] addr,       // address of the word in this handshake
  input  logic [31:0]       hold,
  input  logic [31:0]       word,
  output data_in            u_n_out,
  output data_in            l_n_out
);

  logic [ADDR_W-1:0] prev_addr;

  // Wraps modulo the memory depth, so base 0x1FFFF pairs with 0x00000.
  assign prev_addr = addr - {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] zext(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a};
  endfunction

  // Lane registers: we pulses for one cycle, addr/din keep their last written value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_n_out <= DATA_IN_IDLE;
      l_n_out <= DATA_IN_IDLE;
    end else begin
      u_n_out.we   <= pair_we | single_we;
      l_n_out.we   <= pair_we;
      u_n_out.dout <= '0;
      l_n_out.dout <= '0;
      if (pair_we) begin
        u_n_out.addr <= zext(prev_addr);
        u_n_out.din  <= hold;
        l_n_out.addr <= zext(addr);
        l_n_out.din  <= word;
      end else if (single_we) begin
        u_n_out.addr <= zext(addr);
        u_n_out.din  <= word;
      end
    end
  end

endmodule

// File: rtl/sub_mem_loader.sv
// rtl/sub_mem_loader.sv - fills a subcore data memory two words per cycle from a main-core stream
module sub_mem_loader
  import sub_mem_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic             clk,
  input  logic             rstn,
  sub_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   k;
  logic [ADDR_W:0]   k_next;
  logic [31:0]       hold;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic              last;
  logic              pair_we;
  logic              single_we;

  assign k_next    = k + {{ADDR_W{1'b0}}, 1'b1};
  assign word_addr = base + k[ADDR_W-1:0];
  assign bus.wdata_ready = (state == LOAD) && (k < len);
  assign accept    = bus.wdata_valid && bus.wdata_ready;
  assign last      = accept && (k_next == len);
  // A word accepted together with abort is dropped.
  assign pair_we   = accept && k[0] && !bus.abort;
  assign single_we = last && !k[0] && !bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    next_state    = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) next_state = (bus.cmd_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        bus.busy = 1'b1;
        if (bus.abort)  next_state = IDLE;
        else if (last)  next_state = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = !bus.abort;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command latch, accepted-word count and even-word hold register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base <= '0;
      len  <= '0;
      k    <= '0;
      hold <= '0;
    end else if (state == IDLE && bus.cmd_valid) begin
      base <= bus.cmd_base;
      len  <= bus.cmd_len;
      k    <= '0;
      hold <= '0;
    end else if (state == LOAD && bus.abort) begin
      k    <= '0;
      hold <= '0;
    end else if (accept) begin
      k <= k_next;
      if (!k[0]) hold <= bus.wdata;
    end
  end

  sub_mem_pair_writer #(.ADDR_W(ADDR_W)) u_writer (
    .clk       (clk),
    .rstn      (rstn),
    .pair_we   (pair_we),
    .single_we (single_we),
    .addr      (word_addr),
    .hold      (hold),
    .word      (bus.wdata),
    .u_n_out   (bus.u_n_out),
    .l_n_out   (bus.l_n_out)
  );

endmodule

// File: tb/tb_sub_mem_loader.sv
// tb/tb_sub_mem_loader.sv - scoreboard bench for sub_mem_loader with a word-list reference model
module tb_sub_mem_loader;

  localparam int DEPTH = 1 << 17;
  localparam int AMASK = DEPTH - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sub_mem_loader_if #(.ADDR_W(17)) bus ();

  sub_mem_loader #(.ADDR_W(17)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected memory activity: cycle it must be visible in, both lanes, done pulse.
  typedef struct {
    int          at;
    bit          u_we;
    int          u_addr;
    logic [31:0] u_din;
    bit          l_we;
    int          l_addr;
    logic [31:0] l_din;
    bit          done;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int at, input bit uw, input int ua, input logic [31:0] ud,
                                input bit lw, input int la, input logic [31:0] ld, input bit dn);
    ev_t e;
    e.at = at; e.u_we = uw; e.u_addr = ua & AMASK; e.u_din = ud;
    e.l_we = lw; e.l_addr = la & AMASK; e.l_din = ld; e.done = dn;
    return e;
  endfunction

  // Monitor: any write or done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn && (bus.u_n_out.we || bus.l_n_out.we || bus.done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_activity: u.we=%0b l.we=%0b done=%0b expected none (cycle %0d)",
                 bus.u_n_out.we, bus.l_n_out.we, bus.done, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.at);
        check("u_we", bus.u_n_out.we, e.u_we);
        check("l_we", bus.l_n_out.we, e.l_we);
        check("done", bus.done, e.done);
        if (e.u_we) begin
          check("u_addr", bus.u_n_out.addr, e.u_addr);
          check("u_din", bus.u_n_out.din, e.u_din);
        end
        if (e.l_we) begin
          check("l_addr", bus.l_n_out.addr, e.l_addr);
          check("l_din", bus.l_n_out.din, e.l_din);
        end
        check("dout_zero", {bus.u_n_out.dout, bus.l_n_out.dout}, 0);
      end
    end
  end

  // One command: gap = percent of cycles without a word, abort_at / rst_at = accepted
  // word count at which to abort / reset (-1 = never). Entered and left #1 after a posedge.
  task automatic run_cmd(input int base, input int len, input int gap, input int abort_at, input int rst_at);
    int acc = 0;
    int n;
    int budget = 0;
    bit hs;
    bit aborted = 0;
    bit was_rst = 0;
    logic [31:0] words[$];
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = 17'(base);
    bus.cmd_len   = 18'(len);
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;
    n = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = 17'($urandom);
    if (len == 0) exp_q.push_back(mk_ev(n, 0, 0, 0, 0, 0, 0, 1));
    while (acc < len && !aborted && !was_rst) begin
      bus.wdata_valid = (gap == 0) || ($urandom_range(99) >= gap);
      bus.wdata       = $urandom;
      bus.abort       = (acc == abort_at);
      if (acc == abort_at) bus.wdata_valid = 1'b1;
      @(negedge clk);
      check("wdata_ready_load", bus.wdata_ready, 1);
      check("busy_load", bus.busy, 1);
      check("cmd_ready_load", bus.cmd_ready, 0);
      hs = bus.wdata_valid && bus.wdata_ready;
      @(posedge clk); #1;
      n = cyc;
      if (bus.abort) begin
        aborted = 1;
      end else if (hs) begin
        words.push_back(bus.wdata);
        if (acc % 2 == 1)
          exp_q.push_back(mk_ev(n, 1, base + acc - 1, words[acc-1], 1, base + acc, words[acc], acc + 1 == len));
        else if (acc + 1 == len)
          exp_q.push_back(mk_ev(n, 1, base + acc, words[acc], 0, 0, 0, 1));
        acc++;
      end
      bus.abort       = 1'b0;
      bus.wdata_valid = 1'b0;
      if (acc == rst_at) begin
        #1 rstn = 1'b0;
        #1;
        check("rst_u_zero", bus.u_n_out == 0, 1);
        check("rst_l_zero", bus.l_n_out == 0, 1);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_wdata_ready", bus.wdata_ready, 0);
        check("rst_busy", bus.busy, 0);
        was_rst = 1;
      end
      budget++;
      if (budget > 4 * len + 50) begin
        checks++;
        errors++;
        $display("FAIL word_timeout: accepted %0d of %0d words", acc, len);
        break;
      end
    end
    if (was_rst) begin
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      if (aborted) begin
        check("cmd_ready_after_abort", bus.cmd_ready, 1);
      end else begin
        check("cmd_ready_done", bus.cmd_ready, 0);
        check("busy_done", bus.busy, 1);
      end
      check("wdata_ready_done", bus.wdata_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("cmd_ready_back", bus.cmd_ready, 1);
    check("busy_idle", bus.busy, 0);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_base    = '0;
    bus.cmd_len     = '0;
    bus.abort       = 1'b0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_wdata_ready", bus.wdata_ready, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_u_zero", bus.u_n_out == 0, 1);
    check("reset_l_zero", bus.l_n_out == 0, 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_cmd(32'h00100, 4, 0, -1, -1);
    run_cmd(32'h00010, 3, 50, -1, -1);
    run_cmd(32'h1FFFF, 2, 0, -1, -1);
    run_cmd(32'h00040, 0, 0, -1, -1);
    run_cmd(32'h00500, 8, 0, 3, -1);
    run_cmd(32'h00600, 2, 30, -1, -1);
    for (int i = 0; i < 12; i++) begin
      int b;
      b = (i % 3 == 0) ? (AMASK - int'($urandom_range(3))) : int'($urandom_range(AMASK));
      run_cmd(b, int'($urandom_range(9)), int'($urandom_range(60)), -1, -1);
    end
    run_cmd(32'h02345, 8, 0, -1, 3);
    run_cmd(32'h02345, 2, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
